wave_config_ctrl: RTL

WAVE_CONFIG_CTRL -- requirements
Module: wave_config_ctrl

---
 rtl/wave_config_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/wave_config_ctrl.sv
// Double-buffered waveform configuration: host writes a shadow set, commits copy it to the active set on a frame tick.
// Optional shadow readback port is enabled by defining WCFG_READBACK_EN.
module wave_config_ctrl (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [5:0]    wr_chan,
  input  logic [1:0]    wr_sel,
  input  logic [15:0]   wr_data,
  input  logic          commit_req,
  input  logic          frame_tick,
  output logic          commit_pending,
  output logic          commit_done,
  output logic          wr_err,
`ifdef WCFG_READBACK_EN
  input  logic [5:0]    rd_chan,
  input  logic [1:0]    rd_sel,
  output logic [15:0]   rd_data,
`endif
  output logic [1023:0] amps,
  output logic [1023:0] offsets,
  output logic [1023:0] phasewords
);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t state;

  logic [1023:0] shadow_amp;
  logic [1023:0] shadow_off;
  logic [1023:0] shadow_phase;

  logic       wr_fire;
  logic [9:0] wr_base;

  // Handshake outputs are pure decodes of the state register, so they are glitch-free.
  assign wr_ready       = (state == IDLE);
  assign commit_pending = (state == PENDING);
  assign wr_fire        = wr_valid && wr_ready;
  assign wr_base        = {wr_chan, 4'b0000};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      commit_done  <= 1'b0;
      wr_err       <= 1'b0;
      shadow_amp   <= '0;
      shadow_off   <= '0;
      shadow_phase <= '0;
      amps         <= '0;
      offsets      <= '0;
      phasewords   <= '0;
    end else begin
      commit_done <= 1'b0;
      wr_err      <= 1'b0;

      if (wr_fire) begin
        case (wr_sel)
          2'd0:    shadow_amp[wr_base +: 16]   <= wr_data;
          2'd1:    shadow_off[wr_base +: 16]   <= wr_data;
          2'd2:    shadow_phase[wr_base +: 16] <= wr_data;
          default: wr_err                      <= 1'b1;
        endcase
      end

      // A frame_tick in the accepting cycle is ignored because only PENDING consumes it.
      case (state)
        IDLE: begin
          if (commit_req)
            state <= PENDING;
        end
        PENDING: begin
          if (frame_tick) begin
            amps        <= shadow_amp;
            offsets     <= shadow_off;
            phasewords  <= shadow_phase;
            commit_done <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WCFG_READBACK_EN
  logic [9:0] rd_base;
  assign rd_base = {rd_chan, 4'b0000};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      case (rd_sel)
        2'd0:    rd_data <= shadow_amp[rd_base +: 16];
        2'd1:    rd_data <= shadow_off[rd_base +: 16];
        2'd2:    rd_data <= shadow_phase[rd_base +: 16];
        default: rd_data <= '0;
      endcase
    end
  end
`endif

endmodule
